// File: rtl/i2s_tx.sv
// i2s_tx -- Philips I2S transmitter for the audio FIR output stage.
//
// Takes one mono sample per sample_in_valid pulse into a one-deep holding
// register and transmits it on both channels of a standard I2S frame. All
// serial clocks are derived from clk. The once-per-frame sample_req strobe
// sets the system sample rate: f_clk / (4*CLK_DIV*SLOT_WIDTH).
//
// Parameters:
//   DATA_WIDTH  sample width, 1..SLOT_WIDTH-1
//   SLOT_WIDTH  BCLK periods per channel slot (frame = 2*SLOT_WIDTH)
//   CLK_DIV     clk cycles per BCLK half-period, >= 2
// Ports:
//   clk              system clock, rising edge
//   rst              asynchronous active-low reset
//   sample_in        signed sample from the FIR
//   sample_in_valid  one-cycle qualifier for sample_in
//   sample_req       one-cycle pulse at each frame load
//   bclk             I2S bit clock
//   lrclk            I2S word select (0 = left, 1 = right)
//   sdata            I2S serial data, MSB first, one-BCLK delay
//   underrun         pulse: frame loaded with no new sample pending
//   overrun          pulse: unconsumed pending sample overwritten
module i2s_tx #(
    parameter int DATA_WIDTH = 16,
    parameter int SLOT_WIDTH = 32,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  sample_in_valid,
    output logic                  sample_req,
    output logic                  bclk,
    output logic                  lrclk,
    output logic                  sdata,
    output logic                  underrun,
    output logic                  overrun
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(2 * SLOT_WIDTH);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_WIDTH - 1);
    localparam logic [BIT_W-1:0] SLOT_B   = BIT_W'(SLOT_WIDTH);
    localparam logic [BIT_W-1:0] DATA_B   = BIT_W'(DATA_WIDTH);

    logic [DIV_W-1:0]      div_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [BIT_W-1:0]      bit_cnt_nxt;
    logic [BIT_W-1:0]      slot_pos;
    logic [DATA_WIDTH-1:0] holding;
    logic [DATA_WIDTH-1:0] frame;
    logic [DATA_WIDTH-1:0] frame_shift;
    logic                  pending;
    logic                  div_wrap;
    logic                  bclk_fall;
    logic                  frame_load;
    logic                  sdata_nxt;

    always_comb begin
        div_wrap    = (div_cnt == DIV_LAST);
        bclk_fall   = div_wrap & bclk;
        frame_load  = bclk_fall & (bit_cnt == BIT_LAST);
        bit_cnt_nxt = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
        slot_pos    = (bit_cnt_nxt >= SLOT_B) ? bit_cnt_nxt - SLOT_B : bit_cnt_nxt;
        // Slot position p selects frame[DATA_WIDTH-p]; shifting left by p-1
        // brings that bit to the MSB. Position 0 is the I2S delay bit, and at
        // a frame load the new bit_cnt is 0, so the stale frame is never sent.
        frame_shift = frame << (slot_pos - 1'b1);
        sdata_nxt   = (slot_pos != '0) && (slot_pos <= DATA_B) &&
                      frame_shift[DATA_WIDTH-1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt    <= '0;
            bit_cnt    <= '0;
            holding    <= '0;
            frame      <= '0;
            pending    <= 1'b0;
            bclk       <= 1'b0;
            lrclk      <= 1'b0;
            sdata      <= 1'b0;
            sample_req <= 1'b0;
            underrun   <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
            if (div_wrap) begin
                bclk <= ~bclk;
            end

            if (bclk_fall) begin
                bit_cnt <= bit_cnt_nxt;
                lrclk   <= (bit_cnt_nxt >= SLOT_B);
                sdata   <= sdata_nxt;
            end

            sample_req <= frame_load;
            underrun   <= frame_load & ~pending;
            overrun    <= sample_in_valid & pending & ~frame_load;

            if (frame_load) begin
                frame <= holding;
            end

            // A valid coinciding with a load re-arms pending for the next frame.
            if (sample_in_valid) begin
                holding <= sample_in;
                pending <= 1'b1;
            end else if (frame_load) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx -- bench for i2s_tx with DATA_WIDTH=16, SLOT_WIDTH=32, CLK_DIV=2.
//
// The stimulus process keeps a sample-level model (pending flag, held value,
// cycle count since reset release; loads fall every 4*CLK_DIV*SLOT_WIDTH
// cycles) and pushes the expected frame content into a queue at each load.
// A monitor pops an entry on every sample_req and decodes the following
// serial frame from bclk/lrclk/sdata.
module tb_i2s_tx;

    localparam int DW    = 16;
    localparam int SW    = 32;
    localparam int CD    = 2;
    localparam int FRAME = 4 * CD * SW;
    localparam int BITS  = 2 * SW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] sample_in = '0;
    logic          sample_in_valid = 1'b0;
    logic          sample_req;
    logic          bclk;
    logic          lrclk;
    logic          sdata;
    logic          underrun;
    logic          overrun;

    i2s_tx #(
        .DATA_WIDTH(DW),
        .SLOT_WIDTH(SW),
        .CLK_DIV   (CD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sample_in      (sample_in),
        .sample_in_valid(sample_in_valid),
        .sample_req     (sample_req),
        .bclk           (bclk),
        .lrclk          (lrclk),
        .sdata          (sdata),
        .underrun       (underrun),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] val;
        logic          und;
        int            n;
    } exp_t;

    exp_t          exp_q[$];
    int            total = 0;
    int            bad = 0;
    int            n = 0;
    int            epoch = 0;
    int            pushes = 0;
    int            req_seen = 0;
    int            exp_und = 0;
    int            exp_ovr = 0;
    int            und_seen = 0;
    int            ovr_seen = 0;
    logic          m_pend = 1'b0;
    logic [DW-1:0] m_hold = '0;

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // One clk cycle: drive inputs, advance the model at the rising edge.
    task automatic cycle(input logic v, input logic [DW-1:0] d);
        exp_t e;
        bit   is_load;
        sample_in_valid = v;
        sample_in       = d;
        @(posedge clk);
        n++;
        is_load = (n % FRAME == 0);
        if (is_load) begin
            e.val = m_hold;
            e.und = !m_pend;
            e.n   = n;
            exp_q.push_back(e);
            pushes++;
            if (!m_pend) exp_und++;
        end
        if (v && m_pend && !is_load) exp_ovr++;
        if (v) begin
            m_hold = d;
            m_pend = 1'b1;
        end else if (is_load) begin
            m_pend = 1'b0;
        end
        @(negedge clk);
        sample_in_valid = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) cycle(1'b0, '0);
    endtask

    task automatic wait_load();
        do cycle(1'b0, '0); while (n % FRAME != 0);
    endtask

    task automatic chk_counts(input string tag);
        #1;
        chk({tag, "_underrun_cnt"}, und_seen, exp_und);
        chk({tag, "_overrun_cnt"}, ovr_seen, exp_ovr);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_bclk"}, bclk, 0);
        chk({tag, "_lrclk"}, lrclk, 0);
        chk({tag, "_sdata"}, sdata, 0);
        chk({tag, "_sample_req"}, sample_req, 0);
        chk({tag, "_underrun"}, underrun, 0);
        chk({tag, "_overrun"}, overrun, 0);
    endtask

    task automatic chk_bclk_start(input string tag);
        for (int unsigned k = 1; k <= 2 * CD; k++) begin
            cycle(1'b0, '0);
            chk({tag, "_bclk_start"}, bclk, (k >= CD && k < 2 * CD) ? 1 : 0);
        end
    endtask

    always @(negedge clk) begin
        if (underrun) und_seen <= und_seen + 1;
        if (overrun) ovr_seen <= ovr_seen + 1;
    end

    // Monitor: decode one frame per sample_req.
    exp_t          me;
    int            m_ep;
    int            m_pad;
    int            m_lr_err;
    int            m_bclk_err;
    int            m_stab_err;
    logic [DW-1:0] m_left;
    logic [DW-1:0] m_right;
    logic          m_lo_sd;
    logic          m_lo_lr;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst && sample_req) begin
                req_seen++;
                chk("req_has_expectation", (exp_q.size() > 0) ? 1 : 0, 1);
                if (exp_q.size() > 0) begin
                    me = exp_q.pop_front();
                    chk("req_cycle", n, me.n);
                    chk("underrun_at_load", underrun, me.und);
                    m_ep       = epoch;
                    m_pad      = 0;
                    m_lr_err   = 0;
                    m_bclk_err = 0;
                    m_stab_err = 0;
                    m_left     = '0;
                    m_right    = '0;
                    for (int unsigned b = 0; b < BITS; b++) begin
                        if (b > 0) repeat (CD) @(negedge clk);
                        if (epoch != m_ep) break;
                        if (bclk !== 1'b0) m_bclk_err++;
                        m_lo_sd = sdata;
                        m_lo_lr = lrclk;
                        repeat (CD) @(negedge clk);
                        if (epoch != m_ep) break;
                        if (bclk !== 1'b1) m_bclk_err++;
                        if (sdata !== m_lo_sd || lrclk !== m_lo_lr) m_stab_err++;
                        if (lrclk !== (b >= SW)) m_lr_err++;
                        // Slot layout: delay bit, DW data bits MSB first, zero pad.
                        if ((b % SW) >= 1 && (b % SW) <= DW) begin
                            if (b < SW) m_left  = {m_left[DW-2:0], sdata};
                            else        m_right = {m_right[DW-2:0], sdata};
                        end else if (sdata !== 1'b0) begin
                            m_pad++;
                        end
                    end
                    if (epoch == m_ep) begin
                        chk("left_word", m_left, me.val);
                        chk("right_word", m_right, me.val);
                        chk("pad_bits", m_pad, 0);
                        chk("lrclk_pattern", m_lr_err, 0);
                        chk("bclk_shape", m_bclk_err, 0);
                        chk("sdata_lrclk_stability", m_stab_err, 0);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #(FRAME * 40 * 10);
        $display("FAIL watchdog: simulation exceeded time limit, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b1;
        n   = 0;
        chk_bclk_start("init");

        // 1: free-run, no input
        wait_load();
        wait_load();
        chk_counts("freerun");

        // 2: single sample right after a sample_req
        cycle(1'b1, 16'hA5C3);
        wait_load();
        wait_load();
        chk_counts("single");

        // 3: two samples within one frame
        idle(20);
        cycle(1'b1, 16'h1111);
        idle(50);
        cycle(1'b1, 16'h7FFF);
        wait_load();
        chk_counts("overrun");

        // 4: valid on the exact load cycle with nothing pending
        while ((n + 1) % FRAME != 0) cycle(1'b0, '0);
        cycle(1'b1, 16'h8000);
        wait_load();
        chk_counts("collision");

        // 5: paced ramp, valid three cycles after each sample_req
        for (int unsigned i = 0; i < 8; i++) begin
            idle(2);
            cycle(1'b1, DW'(i));
            wait_load();
        end
        chk_counts("paced");

        // 6: asynchronous reset at bit_cnt 40 of an all-ones frame
        idle(2);
        cycle(1'b1, 16'hFFFF);
        wait_load();
        while (n % FRAME != 4 * 40 + CD) cycle(1'b0, '0);
        chk_counts("pre_reset");
        chk("pre_reset_bclk", bclk, 1);
        chk("pre_reset_lrclk", lrclk, 1);
        chk("pre_reset_sdata", sdata, 1);
        rst = 1'b0;
        epoch++;
        exp_q.delete();
        m_pend = 1'b0;
        m_hold = '0;
        n      = 0;
        #1;
        chk_zero("arst");
        @(negedge clk);
        chk_zero("arst_hold");
        rst = 1'b1;
        chk_bclk_start("post_rst");
        wait_load();
        wait_load();
        idle(FRAME);

        chk_counts("final");
        chk("req_count", req_seen, pushes);
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2s_tx.md
# i2s_tx

- Output stage directly downstream of the audio FIR filter.
- Takes one filtered mono sample per `sample_in_valid` pulse into a one-deep holding register.
- Serializes each sample as a standard Philips I2S stereo frame, with the same sample on both channels, toward the board's audio DAC.
- Generates all serial clocks from `clk` and emits a once-per-frame `sample_req` strobe; this strobe sets the system sample rate and paces upstream synthesis.

## Interface
- `DATA_WIDTH`, 16: sample width, signed two's complement; must satisfy 1 ≤ DATA_WIDTH ≤ SLOT_WIDTH-1.
- `SLOT_WIDTH`, 32: BCLK periods per channel slot; a frame is 2*SLOT_WIDTH BCLK periods.
- `CLK_DIV`, 4: `clk` cycles per BCLK half-period; must be ≥ 2.
- `clk` in 1: system clock; all state on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `sample_in` in DATA_WIDTH: signed sample from the FIR.
- `sample_in_valid` in 1: one-cycle qualifier for `sample_in`.
- `sample_req` out 1: one-cycle pulse at each frame boundary.
- `bclk` out 1: I2S bit clock.
- `lrclk` out 1: I2S word select; 0 = left, 1 = right.
- `sdata` out 1: I2S serial data.
- `underrun` out 1: one-cycle pulse when a frame loads with no new sample pending.
- `overrun` out 1: one-cycle pulse when an unconsumed pending sample is overwritten.

## Operation

**Reset state**
- While `rst`=0, all state is cleared: `div_cnt`, `bit_cnt`, holding register, frame register and `pending`.
- All outputs are 0.

**Clock divider**
- `div_cnt` counts 0..CLK_DIV-1 and wraps.
- On wrap, `bclk` toggles.
- BCLK period is 2*CLK_DIV `clk` cycles.

**Bit counter and serial outputs**
- Falling BCLK update: the `clk` edge that drives `bclk` 1→0.
- At each falling BCLK update, `bit_cnt` (0..2*SLOT_WIDTH-1) increments and wraps.
- `lrclk` and `sdata` are registered and updated in that same `clk` edge, using the new `bit_cnt`.
- `lrclk` = 1 iff `bit_cnt` ≥ SLOT_WIDTH.
- Slot position p = `bit_cnt` mod SLOT_WIDTH.
- `sdata` = frame[DATA_WIDTH-p] for 1 ≤ p ≤ DATA_WIDTH, else 0.
- This gives the I2S one-bit delay: MSB first, zero padding after the LSB.
- The left and right slots carry the identical frame value.

**Frame load**
- Occurs at the falling BCLK update where `bit_cnt` wraps to 0.
- frame ← holding register value as it was before that edge.
- `sample_req` pulses in the same edge.
- If `pending`=1: clear `pending`.
- If `pending`=0: the last sample is repeated and `underrun` pulses.

**Sample input**
- On `sample_in_valid`: holding ← `sample_in` and `pending` ← 1.
- `overrun` pulses if `pending` was 1 and no frame load occurs in the same cycle. The newer sample wins.

**Simultaneous valid and frame load**
- The frame takes the old holding value.
- The new sample becomes pending (`pending` = 1 after the edge).
- No overrun.
- `underrun` pulses iff `pending` was 0 before the edge.

**Reset mid-frame**
- Outputs drop to 0 immediately (asynchronous).
- After release, the frame restarts from `bit_cnt` = 0 with frame = 0.

## Timing
- Sample rate: f_clk / (4*CLK_DIV*SLOT_WIDTH), e.g. 100 MHz, CLK_DIV=4, SLOT_WIDTH=32 → 195.3 kHz.
- First `bclk` rise after reset release: on the CLK_DIV-th `clk` edge. Falls CLK_DIV edges later.
- `sample_req` spacing: exactly 4*CLK_DIV*SLOT_WIDTH cycles.
  - First pulse at the falling BCLK update that wraps `bit_cnt` to 0, i.e. after 2*SLOT_WIDTH BCLK periods.
- Latency from frame load to the left MSB on `sdata`: one BCLK period (2*CLK_DIV cycles).
  - Right MSB follows SLOT_WIDTH BCLK periods after the left MSB.
- A sample accepted while `pending`=0 is transmitted in the next frame load.
- `lrclk` and `sdata` change only coincident with `bclk` falling, so they are stable across every `bclk` rising edge.
- `sample_req`, `underrun` and `overrun` are single-cycle pulses, never stretched.

## Test plan
Default parameters: DATA_WIDTH=16, SLOT_WIDTH=32, CLK_DIV=2 (frame = 256 cycles).

1. **Reset and free-run**
   - Stimulus: release `rst`, no input.
   - Required: `bclk` period 4 cycles; `lrclk` toggles every 128 cycles; `sdata` stays 0; `sample_req` every 256 cycles.
   - Required: `underrun` pulses with every `sample_req`.
2. **Single sample**
   - Stimulus: drive 16'hA5C3 with `sample_in_valid` immediately after a `sample_req`.
   - Required: the next frame shifts bits 1010_0101_1100_0011 in both slots, MSB one BCLK after each `lrclk` edge, followed by 16 zeros.
   - Required: no `underrun` at that load; `underrun` again at the following load.
3. **Overrun**
   - Stimulus: two valids, 16'h1111 then 16'h7FFF, within one frame.
   - Required: `overrun` pulses once; the next frame carries 16'h7FFF.
4. **Collision**
   - Stimulus: valid with 16'h8000 on the exact `sample_req` cycle, with `pending`=0 beforehand.
   - Required: `underrun` pulses and the frame repeats the previous sample; 16'h8000 is sent the frame after; no `overrun`.
5. **Paced stream**
   - Stimulus: respond to each `sample_req` with a valid three cycles later, carrying a ramp 0,1,2,… over 8 frames.
   - Required: frames carry 0..7 in order; no `underrun` after the first sample; no `overrun`.
6. **Asynchronous reset mid-frame**
   - Stimulus: assert `rst` low for one cycle at `bit_cnt` 40.
   - Required: all outputs 0 within that cycle.
   - Required: after release, timing restarts as in scenario 1 and the first frame is all zero.
